// File: rtl/tqvp_ofdm_demap.sv
// tqvp_ofdm_demap: QPSK/16-QAM hard-decision slicer that packs symbol bits into bytes behind a small register file
module tqvp_ofdm_demap (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    typedef enum logic [1:0] {IDLE, SLICE, PACK} state_t;
    state_t state, state_next;
    logic scheme, valid, overrun;
    logic [7:0] sym, data, eras, acc, packed_acc;
    logic [2:0] acc_bits;
    logic [3:0] bits, slice_bits, total;
    logic [8:0] eras_sum;
    logic wr_ctrl, wr_stat, wr_sym, clr, sch_chg, busy, sym_go, done, stat_clr_valid;
    logic signed [3:0] i_val, q_val;
    logic unused_ok;

    // 16-QAM Gray slicer: -8..-2 -> 00, -1 -> 01, 0..1 -> 11, 2..7 -> 10
    function automatic logic [1:0] qam(input logic signed [3:0] v);
        return v[3] ? (&v ? 2'b01 : 2'b00) : (v > 4'sd1 ? 2'b10 : 2'b11);
    endfunction

    assign wr_ctrl        = data_write && address == 4'h0;
    assign wr_stat        = data_write && address == 4'h1;
    assign wr_sym         = data_write && address == 4'h2;
    assign clr            = wr_ctrl && data_in[0];
    assign sch_chg        = wr_ctrl && data_in[1] != scheme;
    assign busy           = state != IDLE;
    assign sym_go         = wr_sym && !busy;
    assign i_val          = sym[3:0];
    assign q_val          = sym[7:4];
    assign slice_bits     = scheme ? {qam(i_val), qam(q_val)} : {2'b00, i_val[3], q_val[3]};
    assign eras_sum       = {1'b0, eras} + {8'b0, ~|sym[3:0]} + {8'b0, ~|sym[7:4]};
    assign total          = {1'b0, acc_bits} + (scheme ? 4'd4 : 4'd2);
    assign done           = total == 4'd8;
    assign packed_acc     = acc | ({4'b0, bits} << acc_bits);
    assign stat_clr_valid = wr_stat && data_in[0];
    assign uo_out         = {6'b0, valid, 1'b0};
    assign unused_ok      = &{1'b0, ui_in};
    assign data_out = address == 4'h0 ? {6'b0, scheme, 1'b0} :
                      address == 4'h1 ? {2'b0, acc_bits, busy, overrun, valid} :
                      address == 4'h2 ? sym :
                      address == 4'h3 ? data :
                      address == 4'h4 ? eras : 8'h00;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    // IDLE -> SLICE on an accepted symbol, SLICE -> PACK -> IDLE; clear or scheme change aborts
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sym_go) state_next = SLICE;
            SLICE:   state_next = PACK;
            default: state_next = IDLE;
        endcase
        if (clr || sch_chg) state_next = IDLE;
    end

    // registers, slicing, erasure counting and byte packing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scheme   <= 1'b0;
            sym      <= 8'h00;
            data     <= 8'h00;
            eras     <= 8'h00;
            acc      <= 8'h00;
            acc_bits <= 3'd0;
            bits     <= 4'h0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ctrl) scheme <= data_in[1];
            if (sym_go) sym <= data_in;
            if (clr) begin
                data     <= 8'h00;
                eras     <= 8'h00;
                acc      <= 8'h00;
                acc_bits <= 3'd0;
                valid    <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (wr_stat && data_in[0]) valid <= 1'b0;
                if (wr_stat && data_in[1]) overrun <= 1'b0;
                if (wr_sym && busy) overrun <= 1'b1;
                if (sch_chg) begin
                    acc      <= 8'h00;
                    acc_bits <= 3'd0;
                end else if (state == SLICE) begin
                    bits <= slice_bits;
                    eras <= eras_sum[8] ? 8'hFF : eras_sum[7:0];
                end else if (state == PACK) begin
                    if (done) begin
                        acc      <= 8'h00;
                        acc_bits <= 3'd0;
                        if (valid && !stat_clr_valid) overrun <= 1'b1;
                        else begin
                            data  <= packed_acc;
                            valid <= 1'b1;
                        end
                    end else begin
                        acc      <= packed_acc;
                        acc_bits <= total[2:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tqvp_ofdm_demap.sv
// tb_tqvp_ofdm_demap: randomized and directed checks of the demapper against a symbol-level model
module tb_tqvp_ofdm_demap;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;
    int m_scheme, m_acc, m_bits, m_data, m_valid, m_ovr, m_eras;

    tqvp_ofdm_demap dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic int qam_m(input int v);
        if (v <= -2) return 0;
        if (v == -1) return 1;
        if (v <= 1) return 3;
        return 2;
    endfunction

    function automatic logic [7:0] exp_status();
        return 8'((m_bits << 3) | (m_ovr << 1) | m_valid);
    endfunction

    task automatic model_reset();
        m_scheme = 0; m_acc = 0; m_bits = 0; m_data = 0; m_valid = 0; m_ovr = 0; m_eras = 0;
    endtask

    task automatic model_sym(input logic [7:0] d);
        int i, q, val;
        i = int'(d[3:0]); if (i > 7) i -= 16;
        q = int'(d[7:4]); if (q > 7) q -= 16;
        m_eras += (i == 0) + (q == 0);
        if (m_eras > 255) m_eras = 255;
        val = m_scheme ? qam_m(i) * 4 + qam_m(q) : (i < 0) * 2 + (q < 0);
        m_acc += val << m_bits;
        m_bits += m_scheme ? 4 : 2;
        if (m_bits == 8) begin
            if (m_valid == 0) begin m_data = m_acc; m_valid = 1; end
            else m_ovr = 1;
            m_acc = 0; m_bits = 0;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); address = a; data_in = d; data_write = 1'b1;
        @(negedge clk); data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk); address = a; #1 v = data_out;
    endtask

    task automatic send_sym(input logic [7:0] d);
        wr(4'h2, d);
        repeat (2) @(negedge clk);
        model_sym(d);
    endtask

    task automatic set_ctrl(input int sch, input int c);
        wr(4'h0, 8'((sch << 1) | c));
        if (c != 0) begin m_acc = 0; m_bits = 0; m_data = 0; m_valid = 0; m_ovr = 0; m_eras = 0; end
        else if (sch != m_scheme) begin m_acc = 0; m_bits = 0; end
        m_scheme = sch;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        model_reset();
        #2;
        for (int a = 0; a < 8; a++) begin
            address = 4'(a); #1;
            checks++;
            if (data_out !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h exp 00", a, data_out); end
        end
        checks++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo got %h exp 00", uo_out); end
        @(negedge clk); rst_n = 1'b1;
        rd(4'hF, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h exp 00", v); end
    endtask

    task automatic test_qpsk_vector();
        logic [7:0] v;
        set_ctrl(0, 1);
        send_sym(8'h11); send_sym(8'h1F); send_sym(8'hFF); send_sym(8'hF1);
        rd(4'h3, v); checks++;
        if (v !== 8'h78) begin errors++; $display("FAIL qpsk_data got %h exp 78", v); end
        rd(4'h1, v); checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL qpsk_status got %h exp 01", v); end
        rd(4'h4, v); checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL qpsk_eras got %h exp 00", v); end
        rd(4'h2, v); checks++;
        if (v !== 8'hF1) begin errors++; $display("FAIL sym_readback got %h exp f1", v); end
        rd(4'h0, v); checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL ctrl_read got %h exp 00", v); end
        checks++;
        if (uo_out !== 8'h02) begin errors++; $display("FAIL qpsk_uo got %h exp 02", uo_out); end
    endtask

    task automatic test_qam_vector();
        logic [7:0] v;
        set_ctrl(1, 1);
        send_sym(8'hDD); send_sym(8'h33);
        rd(4'h3, v); checks++;
        if (v !== 8'hA0) begin errors++; $display("FAIL qam_data got %h exp a0", v); end
        rd(4'h0, v); checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL qam_ctrl got %h exp 02", v); end
    endtask

    task automatic test_erasure();
        logic [7:0] v;
        set_ctrl(1, 1);
        send_sym(8'h00);
        rd(4'h1, v); checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL eras_status got %h exp 20", v); end
        rd(4'h4, v); checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL eras_count got %h exp 02", v); end
        send_sym(8'h88);
        rd(4'h3, v); checks++;
        if (v !== 8'h0F) begin errors++; $display("FAIL eras_data got %h exp 0f", v); end
        rd(4'h4, v); checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL eras_count2 got %h exp 02", v); end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        int first;
        set_ctrl(0, 1);
        repeat (4) send_sym(8'($urandom));
        first = m_data;
        repeat (4) send_sym(8'($urandom));
        rd(4'h3, v); checks++;
        if (v !== 8'(first)) begin errors++; $display("FAIL ovr_data got %h exp %h", v, 8'(first)); end
        rd(4'h1, v); checks++;
        if (v !== 8'h03) begin errors++; $display("FAIL ovr_status got %h exp 03", v); end
        wr(4'h1, 8'h03); m_valid = 0; m_ovr = 0;
        rd(4'h1, v); checks++;
        if (v[1:0] !== 2'b00) begin errors++; $display("FAIL ovr_clear got %b exp 00", v[1:0]); end
    endtask

    task automatic test_latency();
        logic [7:0] d;
        set_ctrl(0, 1);
        d = 8'($urandom);
        @(negedge clk); address = 4'h2; data_in = d; data_write = 1'b1;
        @(negedge clk); data_write = 1'b0; address = 4'h1; #1;
        checks++;
        if (data_out !== 8'h04) begin errors++; $display("FAIL lat_edge_n got %h exp 04", data_out); end
        @(posedge clk); #1;
        checks++;
        if (data_out !== 8'h04) begin errors++; $display("FAIL lat_edge_n1 got %h exp 04", data_out); end
        @(posedge clk); #1;
        model_sym(d);
        checks++;
        if (data_out !== exp_status()) begin errors++; $display("FAIL lat_edge_n2 got %h exp %h", data_out, exp_status()); end
    endtask

    task automatic test_busy_drop();
        logic [7:0] v, a;
        set_ctrl(0, 1);
        a = 8'($urandom);
        @(negedge clk); address = 4'h2; data_in = a; data_write = 1'b1;
        @(negedge clk); data_in = 8'($urandom);
        @(negedge clk); data_write = 1'b0;
        @(negedge clk);
        model_sym(a); m_ovr = 1;
        rd(4'h1, v); checks++;
        if (v !== 8'h12) begin errors++; $display("FAIL busy_drop_status got %h exp 12", v); end
        rd(4'h2, v); checks++;
        if (v !== a) begin errors++; $display("FAIL busy_drop_sym got %h exp %h", v, a); end
    endtask

    task automatic test_scheme_change();
        logic [7:0] v;
        set_ctrl(1, 1);
        send_sym(8'h77);
        rd(4'h1, v); checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL sch_acc4 got %h exp 20", v); end
        set_ctrl(0, 0);
        rd(4'h1, v); checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL sch_acc0 got %h exp 00", v); end
        send_sym(8'h11);
        @(negedge clk); address = 4'h2; data_in = 8'h77; data_write = 1'b1;
        @(negedge clk); address = 4'h0; data_in = 8'h02;
        @(negedge clk); data_write = 1'b0;
        @(negedge clk);
        m_scheme = 1; m_acc = 0; m_bits = 0;
        rd(4'h1, v); checks++;
        if (v !== exp_status()) begin errors++; $display("FAIL sch_abort got %h exp %h", v, exp_status()); end
        send_sym(8'hDD); send_sym(8'h33);
        rd(4'h3, v); checks++;
        if (v !== 8'(m_data)) begin errors++; $display("FAIL sch_after_data got %h exp %h", v, 8'(m_data)); end
    endtask

    task automatic test_collision();
        logic [7:0] v, d;
        set_ctrl(0, 1);
        repeat (4) send_sym(8'($urandom));
        repeat (3) send_sym(8'($urandom));
        d = 8'($urandom);
        @(negedge clk); address = 4'h2; data_in = d; data_write = 1'b1;
        @(negedge clk); data_write = 1'b0;
        @(negedge clk); address = 4'h1; data_in = 8'h01; data_write = 1'b1;
        @(negedge clk); data_write = 1'b0;
        m_valid = 0; model_sym(d);
        rd(4'h3, v); checks++;
        if (v !== 8'(m_data)) begin errors++; $display("FAIL coll_data got %h exp %h", v, 8'(m_data)); end
        rd(4'h1, v); checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL coll_status got %h exp 01", v); end
    endtask

    task automatic test_eras_saturate();
        logic [7:0] v;
        set_ctrl(1, 1);
        repeat (130) send_sym(8'h00);
        rd(4'h4, v); checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL eras_sat got %h exp ff", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        set_ctrl(0, 1);
        send_sym(8'h11); send_sym(8'h1F); send_sym(8'hFF); send_sym(8'hF1);
        wr(4'h2, 8'h5A);
        #2 rst_n = 1'b0;
        address = 4'h1; #1;
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_status got %h exp 00", data_out); end
        address = 4'h3; #1;
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", data_out); end
        checks++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL rst_mid_uo got %h exp 00", uo_out); end
        model_reset();
        @(negedge clk); rst_n = 1'b1; address = 4'h2; data_in = 8'hF1; data_write = 1'b1;
        @(negedge clk); data_write = 1'b0; address = 4'h1; #1;
        checks++;
        if (data_out !== 8'h04) begin errors++; $display("FAIL rst_first_edge got %h exp 04", data_out); end
        @(negedge clk); @(negedge clk);
        model_sym(8'hF1);
        rd(4'h1, v); checks++;
        if (v !== exp_status()) begin errors++; $display("FAIL rst_first_sym got %h exp %h", v, exp_status()); end
    endtask

    task automatic test_random();
        logic [7:0] v;
        int r, c;
        set_ctrl(0, 1);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) set_ctrl($urandom_range(0, 1), 0);
            else if (r == 1) begin
                c = $urandom_range(0, 3);
                wr(4'h1, 8'(c));
                if (c & 1) m_valid = 0;
                if (c & 2) m_ovr = 0;
            end else send_sym(8'($urandom));
            rd(4'h3, v); checks++;
            if (v !== 8'(m_data)) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", n, v, 8'(m_data)); end
            rd(4'h1, v); checks++;
            if (v !== exp_status()) begin errors++; $display("FAIL rand_status[%0d] got %h exp %h", n, v, exp_status()); end
            rd(4'h4, v); checks++;
            if (v !== 8'(m_eras)) begin errors++; $display("FAIL rand_eras[%0d] got %h exp %h", n, v, 8'(m_eras)); end
        end
    endtask

    initial begin
        test_reset();
        test_qpsk_vector();
        test_qam_vector();
        test_erasure();
        test_overrun();
        test_latency();
        test_busy_drop();
        test_scheme_change();
        test_collision();
        test_eras_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
